// File: rtl/shiftcorrection_pipe_pkg.sv
// Shared configuration for the postproc shift-correction pipeline.
// Supplies the cvw_t width record (NE, NF, NORMSHIFTSZ, CORRSHIFTSZ) and its default value.
package shiftcorrection_pipe_pkg;

    typedef struct packed {
        int NE;
        int NF;
        int NORMSHIFTSZ;
        int CORRSHIFTSZ;
    } cvw_t;

    // Double-precision FMA sizing: 3*NF+4 corrected sum bits, plus 2 pad bits in Mf.
    localparam cvw_t CVW_DEFAULT = '{
        NE:          11,
        NF:          52,
        NORMSHIFTSZ: 164,
        CORRSHIFTSZ: 162
    };

endpackage

// File: rtl/shiftcorrection_pipe_datapath.sv
// Combinational LZA / divsqrt shift correction and exponent fixups.
// Ports: Shifted/op flags in -> Mf, Asr, ResSubnorm; E* exponent operands in -> FmaMe, Qe.
module shiftcorr_datapath
    import shiftcorrection_pipe_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
) (
    input  logic [P.NORMSHIFTSZ-1:0] Shifted,
    input  logic                     FmaOp,
    input  logic                     DivOp,
    input  logic                     DivResSubnorm,
    input  logic                     FmaPreResultSubnorm,
    input  logic [P.NE+1:0]          DivQe,
    output logic [P.CORRSHIFTSZ-1:0] Mf,
    output logic                     Asr,
    output logic                     ResSubnorm,
    input  logic                     EAsr,
    input  logic                     EResSubnorm,
    input  logic                     EFmaPre,
    input  logic                     EFmaSZero,
    input  logic                     EDivResSubnorm,
    input  logic                     EDivShiftPos,
    input  logic [P.NE+1:0]          EDivQe,
    input  logic [P.NE+1:0]          ENormSumExp,
    output logic [P.NE+1:0]          FmaMe,
    output logic [P.NE+1:0]          Qe
);
    localparam int NSZ = P.NORMSHIFTSZ;
    localparam int CSZ = P.CORRSHIFTSZ;
    localparam int FW  = 3 * P.NF + 4;
    localparam int EW  = P.NE + 2;

    logic [FW-1:0]  CorrSum;
    logic [CSZ-1:0] CorrQm;
    logic           LeftQ;
    logic [EW-1:0]  MeSum;

    assign Asr = Shifted[NSZ-1];

    // Only the low FW bits of the corrected sum survive into Mf.
    assign CorrSum = Asr ? Shifted[FW:1] : Shifted[FW-1:0];

    assign LeftQ  = Asr | (DivQe == EW'(1));
    assign CorrQm = LeftQ ? Shifted[NSZ-2 -: CSZ] : Shifted[NSZ-3 -: CSZ];

    always_comb begin
        Mf = Shifted[NSZ-1 -: CSZ];
        if (FmaOp)
            Mf = {CorrSum, {(CSZ-FW){1'b0}}};
        else if (DivOp & ~DivResSubnorm)
            Mf = CorrQm;
    end

    assign ResSubnorm = FmaPreResultSubnorm & ~Shifted[NSZ-1] & ~Shifted[NSZ-2];

    assign MeSum = ENormSumExp + {{(EW-1){1'b0}}, EAsr}
                 + {{(EW-1){1'b0}}, EFmaPre};
    assign FmaMe = (EFmaSZero | EResSubnorm) ? '0 : MeSum;

    // Without the LZA +1 the quotient exponent drops by one.
    assign Qe = (EDivResSubnorm & EDivShiftPos) ? '0
              : EDivQe - {{(EW-1){1'b0}}, ~EAsr};

endmodule

// File: rtl/shiftcorrection_pipe.sv
// Pipelined shift-correction stage between the norm shifter and the rounder.
// Ports: valid/ready in (InValid/InReady) and out (OutValid/OutReady), Flush, op data in,
// corrected Mf/FmaMe/Qe/ResSubnorm out, saturating LzaCorrCnt out.
module shiftcorrection_pipe
    import shiftcorrection_pipe_pkg::*;
#(
    parameter cvw_t P      = CVW_DEFAULT,
    parameter int   STAGES = 1,
    parameter int   CNTW   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Flush,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [P.NORMSHIFTSZ-1:0] Shifted,
    input  logic                     DivOp,
    input  logic                     FmaOp,
    input  logic                     DivResSubnorm,
    input  logic                     DivSubnormShiftPos,
    input  logic [P.NE+1:0]          DivQe,
    input  logic [P.NE+1:0]          NormSumExp,
    input  logic                     FmaPreResultSubnorm,
    input  logic                     FmaSZero,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [P.CORRSHIFTSZ-1:0] Mf,
    output logic [P.NE+1:0]          FmaMe,
    output logic [P.NE+1:0]          Qe,
    output logic                     ResSubnorm,
    output logic [CNTW-1:0]          LzaCorrCnt
);
    localparam int CSZ = P.CORRSHIFTSZ;
    localparam int EW  = P.NE + 2;

    logic           accept;
    logic [CSZ-1:0] dMf;
    logic           dAsr, dRs;
    logic [EW-1:0]  dFmaMe, dQe;
    logic           eAsr, eRs, ePre, eSz, eDrs, ePos;
    logic [EW-1:0]  eQe, eNse;
    logic [CNTW-1:0] cnt_q, cnt_d;

    assign accept = InValid & InReady & ~Flush;

    shiftcorr_datapath #(.P(P)) u_dp (
        .Shifted            (Shifted),
        .FmaOp              (FmaOp),
        .DivOp              (DivOp),
        .DivResSubnorm      (DivResSubnorm),
        .FmaPreResultSubnorm(FmaPreResultSubnorm),
        .DivQe              (DivQe),
        .Mf                 (dMf),
        .Asr                (dAsr),
        .ResSubnorm         (dRs),
        .EAsr               (eAsr),
        .EResSubnorm        (eRs),
        .EFmaPre            (ePre),
        .EFmaSZero          (eSz),
        .EDivResSubnorm     (eDrs),
        .EDivShiftPos       (ePos),
        .EDivQe             (eQe),
        .ENormSumExp        (eNse),
        .FmaMe              (dFmaMe),
        .Qe                 (dQe)
    );

    generate
        if (STAGES == 1) begin : g_s1
            logic           v_q, v_d;
            logic [CSZ-1:0] mf_q;
            logic [EW-1:0]  me_q, qe_q;
            logic           rs_q;

            assign eAsr = dAsr;
            assign eRs  = dRs;
            assign ePre = FmaPreResultSubnorm;
            assign eSz  = FmaSZero;
            assign eDrs = DivResSubnorm;
            assign ePos = DivSubnormShiftPos;
            assign eQe  = DivQe;
            assign eNse = NormSumExp;

            assign InReady = ~v_q | OutReady;
            assign v_d = Flush ? 1'b0 : (InReady ? InValid : v_q);

            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q  <= 1'b0;
                    mf_q <= '0;
                    me_q <= '0;
                    qe_q <= '0;
                    rs_q <= 1'b0;
                end else begin
                    v_q <= v_d;
                    if (accept) begin
                        mf_q <= dMf;
                        me_q <= dFmaMe;
                        qe_q <= dQe;
                        rs_q <= dRs;
                    end
                end
            end

            assign OutValid   = v_q;
            assign Mf         = mf_q;
            assign FmaMe      = me_q;
            assign Qe         = qe_q;
            assign ResSubnorm = rs_q;
        end else if (STAGES == 2) begin : g_s2
            logic           va_q, va_d, vb_q, vb_d, readyB;
            logic [CSZ-1:0] amf_q, bmf_q;
            logic           aasr_q, ars_q, apre_q, asz_q, adrs_q, apos_q;
            logic [EW-1:0]  aqe_q, anse_q;
            logic [EW-1:0]  bme_q, bqe_q;
            logic           brs_q;

            // Stage A holds the significand result and the raw exponent
            // operands; the exponent fixups are resolved on the way into B.
            assign eAsr = aasr_q;
            assign eRs  = ars_q;
            assign ePre = apre_q;
            assign eSz  = asz_q;
            assign eDrs = adrs_q;
            assign ePos = apos_q;
            assign eQe  = aqe_q;
            assign eNse = anse_q;

            assign readyB  = ~vb_q | OutReady;
            assign InReady = ~va_q | readyB;
            assign va_d = Flush ? 1'b0 : (InReady ? InValid : va_q);
            assign vb_d = Flush ? 1'b0 : (readyB ? va_q : vb_q);

            always_ff @(posedge clk) begin
                if (reset) begin
                    va_q   <= 1'b0;
                    vb_q   <= 1'b0;
                    amf_q  <= '0;
                    aasr_q <= 1'b0;
                    ars_q  <= 1'b0;
                    apre_q <= 1'b0;
                    asz_q  <= 1'b0;
                    adrs_q <= 1'b0;
                    apos_q <= 1'b0;
                    aqe_q  <= '0;
                    anse_q <= '0;
                    bmf_q  <= '0;
                    bme_q  <= '0;
                    bqe_q  <= '0;
                    brs_q  <= 1'b0;
                end else begin
                    va_q <= va_d;
                    vb_q <= vb_d;
                    if (accept) begin
                        amf_q  <= dMf;
                        aasr_q <= dAsr;
                        ars_q  <= dRs;
                        apre_q <= FmaPreResultSubnorm;
                        asz_q  <= FmaSZero;
                        adrs_q <= DivResSubnorm;
                        apos_q <= DivSubnormShiftPos;
                        aqe_q  <= DivQe;
                        anse_q <= NormSumExp;
                    end
                    if (readyB & va_q) begin
                        bmf_q <= amf_q;
                        bme_q <= dFmaMe;
                        bqe_q <= dQe;
                        brs_q <= ars_q;
                    end
                end
            end

            assign OutValid   = vb_q;
            assign Mf         = bmf_q;
            assign FmaMe      = bme_q;
            assign Qe         = bqe_q;
            assign ResSubnorm = brs_q;
        end else begin : g_bad
            $error("shiftcorrection_pipe: STAGES must be 1 or 2");
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (accept & FmaOp & dAsr & ~(&cnt_q))
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign LzaCorrCnt = cnt_q;

endmodule

// File: tb/tb_shiftcorrection_pipe.sv
// Self-checking bench for shiftcorrection_pipe (STAGES=2, CNTW=4).
// Directed corner cases plus random traffic checked against a queue-based reference model.
module tb_shiftcorrection_pipe;
    import shiftcorrection_pipe_pkg::*;

    localparam int ST   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [163:0] sh;
        logic         fma, div, drs, pos, pre, sz;
        logic [12:0]  dq, nse;
    } op_t;

    typedef struct {
        logic [161:0] mf;
        logic [12:0]  me, qe;
        logic         rs;
    } exp_t;

    logic clk = 1'b0;
    logic reset, Flush, InValid, InReady, OutValid, OutReady, ResSubnorm;
    logic [161:0] Mf;
    logic [12:0]  FmaMe, Qe;
    logic [CW-1:0] LzaCorrCnt;
    op_t cur;

    int total = 0;
    int passed = 0;
    int cnt_m = 0;
    bit hold_prev = 0;
    exp_t last;
    exp_t q[$];

    always #5 clk = ~clk;

    shiftcorrection_pipe #(.P(CVW_DEFAULT), .STAGES(ST), .CNTW(CW)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .Shifted(cur.sh), .DivOp(cur.div), .FmaOp(cur.fma),
        .DivResSubnorm(cur.drs), .DivSubnormShiftPos(cur.pos),
        .DivQe(cur.dq), .NormSumExp(cur.nse),
        .FmaPreResultSubnorm(cur.pre), .FmaSZero(cur.sz),
        .OutValid(OutValid), .OutReady(OutReady),
        .Mf(Mf), .FmaMe(FmaMe), .Qe(Qe), .ResSubnorm(ResSubnorm),
        .LzaCorrCnt(LzaCorrCnt)
    );

    task automatic chk(input string tag, input logic [163:0] obs,
                       input logic [163:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: corrections expressed as plain shifts and modular sums.
    function automatic exp_t model(input op_t o);
        exp_t e;
        logic asr;
        logic leftq;
        logic [163:0] t;
        int s;
        asr = o.sh[163];
        if (o.fma) begin
            t = (o.sh >> asr) & ((164'd1 << 160) - 164'd1);
            t = t << 2;
        end else if (o.div && !o.drs) begin
            leftq = asr || (o.dq == 13'd1);
            t = o.sh >> leftq;
        end else begin
            t = o.sh >> 2;
        end
        e.mf = t[161:0];
        e.rs = o.pre && (o.sh[163:162] == 2'b00);
        s = (int'(o.nse) + int'(asr) + int'(o.pre)) % 8192;
        e.me = (o.sz || e.rs) ? 13'd0 : 13'(s);
        s = int'(o.dq) - (asr ? 0 : 1);
        if (s < 0) s += 8192;
        e.qe = (o.drs && o.pos) ? 13'd0 : 13'(s);
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        logic [191:0] r;
        int k;
        r = {$urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom()};
        k = $urandom_range(0, 2);
        o.sh  = r[163:0];
        o.fma = (k == 0);
        o.div = (k == 1);
        o.drs = 1'($urandom_range(0, 1));
        o.pos = 1'($urandom_range(0, 1));
        o.pre = 1'($urandom_range(0, 1));
        o.sz  = ($urandom_range(0, 7) == 0);
        o.dq  = ($urandom_range(0, 3) == 0) ? 13'd1 : 13'($urandom());
        o.nse = 13'($urandom());
        return o;
    endfunction

    // One clock: sample at negedge, score, then return #1 after posedge.
    task automatic tick(output bit acc);
        exp_t e;
        @(negedge clk);
        chk("cnt", 164'(LzaCorrCnt), 164'(cnt_m));
        if (hold_prev) begin
            chk("hold_valid", 164'(OutValid), 164'd1);
            chk("hold_mf", 164'(Mf), 164'(last.mf));
            chk("hold_me", 164'(FmaMe), 164'(last.me));
            chk("hold_qe", 164'(Qe), 164'(last.qe));
        end
        acc = InValid & InReady & ~Flush;
        if (OutValid) begin
            chk("out_expected", 164'(q.size() > 0), 164'd1);
        end
        if (OutValid && OutReady && q.size() > 0) begin
            e = q.pop_front();
            chk("mf", 164'(Mf), 164'(e.mf));
            chk("fmame", 164'(FmaMe), 164'(e.me));
            chk("qe", 164'(Qe), 164'(e.qe));
            chk("ressub", 164'(ResSubnorm), 164'(e.rs));
        end
        hold_prev = OutValid & ~OutReady & ~Flush;
        last.mf = Mf;
        last.me = FmaMe;
        last.qe = Qe;
        if (Flush) q.delete();
        if (acc) begin
            q.push_back(model(cur));
            if (cur.fma && cur.sh[163] && cnt_m < CMAX) cnt_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        InValid = 1'b0;
        Flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        cnt_m = 0;
        hold_prev = 0;
    endtask

    task automatic send1(input op_t o);
        bit a;
        cur = o;
        InValid = 1'b1;
        tick(a);
        InValid = 1'b0;
    endtask

    task automatic drain();
        bit a;
        int n = 0;
        InValid = 1'b0;
        OutReady = 1'b1;
        while (q.size() > 0 && n < 20) begin
            tick(a);
            n++;
        end
        chk("drain_left", 164'(q.size()), 164'd0);
        tick(a);
        chk("drain_ov", 164'(OutValid), 164'd0);
    endtask

    initial begin
        op_t o;
        bit a;
        int sent;

        reset = 1'b1;
        Flush = 1'b0;
        InValid = 1'b0;
        OutReady = 1'b1;
        cur = rand_op();
        do_reset();

        chk("rst_ov", 164'(OutValid), 164'd0);
        chk("rst_cnt", 164'(LzaCorrCnt), 164'd0);
        chk("rst_mf", 164'(Mf), 164'd0);
        chk("rst_me", 164'(FmaMe), 164'd0);
        chk("rst_qe", 164'(Qe), 164'd0);
        chk("rst_rs", 164'(ResSubnorm), 164'd0);
        chk("rst_inready", 164'(InReady), 164'd1);

        // FMA with LZA +1: latency and exponent bump.
        o = rand_op();
        o.fma = 1; o.div = 0; o.sh[163] = 1'b1;
        o.nse = 13'd100; o.pre = 0; o.sz = 0;
        send1(o);
        chk("lat_early", 164'(OutValid), 164'd0);
        tick(a);
        chk("lat_ov", 164'(OutValid), 164'd1);
        chk("lat_me", 164'(FmaMe), 164'd101);
        chk("lat_cnt", 164'(LzaCorrCnt), 164'd1);
        drain();

        // Subnormal FMA prediction, top bits 00 then 01.
        o = rand_op();
        o.fma = 1; o.div = 0; o.pre = 1; o.sz = 0;
        o.sh[163:162] = 2'b00; o.nse = 13'd50;
        send1(o);
        tick(a);
        chk("sub_rs", 164'(ResSubnorm), 164'd1);
        chk("sub_me", 164'(FmaMe), 164'd0);
        o.sh[163:162] = 2'b01;
        send1(o);
        tick(a);
        chk("sub01_me", 164'(FmaMe), 164'd51);
        drain();

        // Divsqrt exponent fixups.
        o = rand_op();
        o.fma = 0; o.div = 1; o.sh[163] = 0;
        o.dq = 13'd1023; o.drs = 0;
        send1(o);
        tick(a);
        chk("div_qe", 164'(Qe), 164'd1022);
        o.drs = 1; o.pos = 1;
        send1(o);
        tick(a);
        chk("divsub_qe", 164'(Qe), 164'd0);
        drain();

        // Eight back-to-back ops with downstream stalled on cycles 3..5.
        sent = 0;
        for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
            if (sent < 8) begin
                if (c == 0 || a) cur = rand_op();
                InValid = 1'b1;
            end else begin
                InValid = 1'b0;
            end
            OutReady = !(c >= 3 && c <= 5);
            tick(a);
            if (a) sent++;
        end
        chk("b2b_sent", 164'(sent), 164'd8);
        drain();

        // Flush with two in flight plus one presented.
        OutReady = 1'b0;
        send1(rand_op());
        send1(rand_op());
        cur = rand_op();
        InValid = 1'b1;
        Flush = 1'b1;
        tick(a);
        Flush = 1'b0;
        InValid = 1'b0;
        OutReady = 1'b1;
        chk("flush_ov", 164'(OutValid), 164'd0);
        for (int i = 0; i < 4; i++) tick(a);
        chk("flush_q", 164'(q.size()), 164'd0);

        // Random traffic with random back-pressure.
        for (int c = 0; c < 200; c++) begin
            if (c == 0 || a || !InValid) cur = rand_op();
            InValid = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 2) != 0);
            tick(a);
        end
        drain();

        // Counter saturation from a fresh reset.
        do_reset();
        OutReady = 1'b1;
        for (int i = 0; i < CMAX + 4; i++) begin
            o = rand_op();
            o.fma = 1; o.div = 0; o.sh[163] = 1'b1;
            cur = o;
            InValid = 1'b1;
            tick(a);
        end
        InValid = 1'b0;
        drain();
        chk("cnt_sat", 164'(LzaCorrCnt), 164'(CMAX));

        // Reset in the middle of a stalled stream.
        OutReady = 1'b0;
        send1(rand_op());
        send1(rand_op());
        do_reset();
        chk("mid_ov", 164'(OutValid), 164'd0);
        chk("mid_cnt", 164'(LzaCorrCnt), 164'd0);
        chk("mid_mf", 164'(Mf), 164'd0);
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) tick(a);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
